// File: rtl/tmds_encode_lx45.sv
// DVI/TMDS encoder: 3-3-2 rgb -> three DC-balanced 10-bit symbols, 3-clock latency.
// Build option TMDS_SCANLINE_EN (adds SYNC_ACTIVE_LOW): halves colours on odd lines.
module tmds_encode_lx45
`ifdef TMDS_SCANLINE_EN
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
)
`endif
(
    input  logic       clk25m,
    input  logic       reset,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       blank_i,
    input  logic [7:0] rgb_i,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2
);

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    // Transition-minimising stage; bit 8 records XOR (1) or XNOR (0) chaining.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    // DC-balancing stage: returns {symbol[9:0], next running disparity[4:0]}.
    function automatic logic [14:0] tmds_sym(input logic [8:0] qm, input logic [3:0] n1q,
                                             input logic signed [4:0] cnt);
        logic signed [5:0] diff;
        logic signed [5:0] c6;
        logic signed [5:0] nxt;
        logic [9:0]        sym;
        diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        c6   = {cnt[4], cnt};
        if ((cnt == 5'sd0) || (n1q == 4'd4)) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nxt = qm[8] ? (c6 + diff) : (c6 - diff);
        end else if (((cnt > 5'sd0) && (n1q > 4'd4)) || ((cnt < 5'sd0) && (n1q < 4'd4))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = c6 - diff + (qm[8] ? 6'sd2 : 6'sd0);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = c6 + diff - (qm[8] ? 6'sd0 : 6'sd2);
        end
        return {sym, nxt[4:0]};
    endfunction

    function automatic logic [9:0] ctl_token(input logic c1, input logic c0);
        logic [9:0] t;
        case ({c1, c0})
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    // S1: registered inputs
    logic       blank_s1, hs_s1, vs_s1;
    logic [7:0] rgb_s1;

    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            blank_s1 <= 1'b1;
            hs_s1    <= 1'b0;
            vs_s1    <= 1'b0;
            rgb_s1   <= 8'd0;
        end else begin
            blank_s1 <= blank_i;
            hs_s1    <= hsync_i;
            vs_s1    <= vsync_i;
            rgb_s1   <= rgb_i;
        end
    end

`ifdef TMDS_SCANLINE_EN
    localparam logic SYNC_ON = !SYNC_ACTIVE_LOW;

    logic hs_prev, vs_prev, parity, parity_eff, hs_edge, vs_edge;

    // The pixel that arrives with the edge already sees the new parity.
    always_comb begin
        hs_edge    = (hs_s1 == SYNC_ON) && (hs_prev != SYNC_ON);
        vs_edge    = (vs_s1 == SYNC_ON) && (vs_prev != SYNC_ON);
        parity_eff = parity;
        if (vs_edge)      parity_eff = 1'b0;
        else if (hs_edge) parity_eff = ~parity;
    end

    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            parity  <= 1'b0;
        end else begin
            hs_prev <= hs_s1;
            vs_prev <= vs_s1;
            parity  <= parity_eff;
        end
    end
`endif

    logic [7:0] r8, g8, b8;

    always_comb begin
        r8 = {rgb_s1[7:5], rgb_s1[7:5], rgb_s1[7:6]};
        g8 = {rgb_s1[4:2], rgb_s1[4:2], rgb_s1[4:3]};
        b8 = {4{rgb_s1[1:0]}};
`ifdef TMDS_SCANLINE_EN
        if (parity_eff) begin
            r8 = {1'b0, r8[7:1]};
            g8 = {1'b0, g8[7:1]};
            b8 = {1'b0, b8[7:1]};
        end
`endif
    end

    // S2: q_m and its ones count per channel
    logic [8:0] qm_r_d, qm_g_d, qm_b_d;
    logic [8:0] qm_r, qm_g, qm_b;
    logic [3:0] n1_r, n1_g, n1_b;
    logic       blank_s2, hs_s2, vs_s2;

    assign qm_r_d = tmds_qm(r8);
    assign qm_g_d = tmds_qm(g8);
    assign qm_b_d = tmds_qm(b8);

    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            qm_r     <= 9'd0;
            qm_g     <= 9'd0;
            qm_b     <= 9'd0;
            n1_r     <= 4'd0;
            n1_g     <= 4'd0;
            n1_b     <= 4'd0;
            blank_s2 <= 1'b1;
            hs_s2    <= 1'b0;
            vs_s2    <= 1'b0;
        end else begin
            qm_r     <= qm_r_d;
            qm_g     <= qm_g_d;
            qm_b     <= qm_b_d;
            n1_r     <= popcount8(qm_r_d[7:0]);
            n1_g     <= popcount8(qm_g_d[7:0]);
            n1_b     <= popcount8(qm_b_d[7:0]);
            blank_s2 <= blank_s1;
            hs_s2    <= hs_s1;
            vs_s2    <= vs_s1;
        end
    end

    // S3: symbol select and running disparity
    logic signed [4:0] cnt_r, cnt_g, cnt_b;
    logic [14:0]       enc_r, enc_g, enc_b;

    assign enc_r = tmds_sym(qm_r, n1_r, cnt_r);
    assign enc_g = tmds_sym(qm_g, n1_g, cnt_g);
    assign enc_b = tmds_sym(qm_b, n1_b, cnt_b);

    always_ff @(posedge clk25m or posedge reset) begin
        if (reset) begin
            tmds_ch0 <= 10'h354;
            tmds_ch1 <= 10'h354;
            tmds_ch2 <= 10'h354;
            cnt_r    <= 5'sd0;
            cnt_g    <= 5'sd0;
            cnt_b    <= 5'sd0;
        end else if (blank_s2) begin
            tmds_ch0 <= ctl_token(vs_s2, hs_s2);
            tmds_ch1 <= 10'h354;
            tmds_ch2 <= 10'h354;
            cnt_r    <= 5'sd0;
            cnt_g    <= 5'sd0;
            cnt_b    <= 5'sd0;
        end else begin
            tmds_ch0 <= enc_b[14:5];
            tmds_ch1 <= enc_g[14:5];
            tmds_ch2 <= enc_r[14:5];
            cnt_b    <= enc_b[4:0];
            cnt_g    <= enc_g[4:0];
            cnt_r    <= enc_r[4:0];
        end
    end

endmodule

// File: tb/tb_tmds_encode_lx45.sv
// Bench for tmds_encode_lx45: hand-computed directed symbols, then a short
// synthetic frame checked by decoding the symbols and tracking disparity.
`timescale 1ns/1ps
module tb_tmds_encode_lx45;

    // clock / reset
    logic       clk25m  = 1'b0;
    logic       reset   = 1'b1;
    logic       hsync_i = 1'b1;
    logic       vsync_i = 1'b1;
    logic       blank_i = 1'b1;
    logic [7:0] rgb_i   = 8'h00;
    logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;

    always #20 clk25m = ~clk25m;

    tmds_encode_lx45 dut (
        .clk25m  (clk25m),
        .reset   (reset),
        .hsync_i (hsync_i),
        .vsync_i (vsync_i),
        .blank_i (blank_i),
        .rgb_i   (rgb_i),
        .tmds_ch0(tmds_ch0),
        .tmds_ch1(tmds_ch1),
        .tmds_ch2(tmds_ch2)
    );

    // scoreboard state: {blank, vsync, hsync, r8, g8, b8}
    int          n_checks = 0;
    int          n_errs   = 0;
    logic [26:0] exp_q[$];
    int          disp[3];
    logic        m_par, m_hs_prev, m_vs_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                          input logic [9:0] e2);
        check({tag, "_ch0"}, {22'd0, tmds_ch0}, {22'd0, e0});
        check({tag, "_ch1"}, {22'd0, tmds_ch1}, {22'd0, e1});
        check({tag, "_ch2"}, {22'd0, tmds_ch2}, {22'd0, e2});
    endtask

    // driver tasks: inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk25m);
        @(negedge clk25m);
    endtask

    task automatic set_in(input logic b, input logic hs, input logic vs, input logic [7:0] rgb);
        blank_i = b;
        hsync_i = hs;
        vsync_i = vs;
        rgb_i   = rgb;
    endtask

    function automatic logic [7:0] tmds_dec(input logic [9:0] s);
        logic [7:0] d, o;
        d    = s[9] ? ~s[7:0] : s[7:0];
        o    = 8'd0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    function automatic logic [9:0] exp_token(input logic c1, input logic c0);
        logic [9:0] t;
        if (!c1 && !c0)     t = 10'h354;
        else if (!c1 && c0) t = 10'h0AB;
        else if (c1 && !c0) t = 10'h154;
        else                t = 10'h2AB;
        return t;
    endfunction

    task automatic check_out(input logic [26:0] rec);
        logic [9:0] sym[3];
        sym[0] = tmds_ch0;
        sym[1] = tmds_ch1;
        sym[2] = tmds_ch2;
        if (rec[26]) begin
            check("blank_ch0", {22'd0, tmds_ch0}, {22'd0, exp_token(rec[25], rec[24])});
            check("blank_ch1", {22'd0, tmds_ch1}, 32'h354);
            check("blank_ch2", {22'd0, tmds_ch2}, 32'h354);
            for (int c = 0; c < 3; c++) disp[c] = 0;
        end else begin
            check("dec_blue",  {24'd0, tmds_dec(tmds_ch0)}, {24'd0, rec[7:0]});
            check("dec_green", {24'd0, tmds_dec(tmds_ch1)}, {24'd0, rec[15:8]});
            check("dec_red",   {24'd0, tmds_dec(tmds_ch2)}, {24'd0, rec[23:16]});
            for (int c = 0; c < 3; c++) begin
                disp[c] = disp[c] + 2 * $countones(sym[c]) - 10;
                check("disp_range", {31'd0, (disp[c] >= -8) && (disp[c] <= 8)}, 32'd1);
            end
        end
    endtask

    // one pixel through the model; compare once the 3-deep pipeline is full
    task automatic drive_px(input logic b, input logic hs, input logic vs, input logic [7:0] rgb);
        logic [7:0] r8, g8, b8;
        set_in(b, hs, vs, rgb);
        if (!vs && m_vs_prev)      m_par = 1'b0;
        else if (!hs && m_hs_prev) m_par = ~m_par;
        m_hs_prev = hs;
        m_vs_prev = vs;
        r8 = {rgb[7:5], rgb[7:5], rgb[7:6]};
        g8 = {rgb[4:2], rgb[4:2], rgb[4:3]};
        b8 = {rgb[1:0], rgb[1:0], rgb[1:0], rgb[1:0]};
`ifdef TMDS_SCANLINE_EN
        if (m_par) begin
            r8 = r8 >> 1;
            g8 = g8 >> 1;
            b8 = b8 >> 1;
        end
`endif
        exp_q.push_back({b, vs, hs, r8, g8, b8});
        step();
        if (exp_q.size() == 3) check_out(exp_q.pop_front());
    endtask

    initial begin
        // reset held with active-video inputs, then released
        set_in(1'b0, 1'b1, 1'b1, 8'h00);
        step();
        step();
        check3("rst_hold", 10'h354, 10'h354, 10'h354);
        reset = 1'b0;
        step();
        check3("rel_clk1", 10'h354, 10'h354, 10'h354);
        step();
        check3("rel_clk2", 10'h354, 10'h354, 10'h354);
        step();
        check3("black_px0", 10'h100, 10'h100, 10'h100);
        step();
        check3("black_px1", 10'h3FF, 10'h3FF, 10'h3FF);
        step();
        check3("black_px2", 10'h100, 10'h100, 10'h100);

        // asynchronous reset mid-line, no clock edge in between
        reset = 1'b1;
        #1;
        check3("async_rst", 10'h354, 10'h354, 10'h354);
        step();
        reset = 1'b0;

        // control tokens during blanking
        set_in(1'b1, 1'b0, 1'b1, 8'h00);
        repeat (3) step();
        check3("tok_vs", 10'h154, 10'h354, 10'h354);
        set_in(1'b1, 1'b1, 1'b1, 8'h00);
        repeat (3) step();
        check3("tok_hs_vs", 10'h2AB, 10'h354, 10'h354);
        set_in(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) step();
        check3("tok_hs", 10'h0AB, 10'h354, 10'h354);

        // black pixels straight after blanking
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (3) step();
        check3("blk_px0", 10'h100, 10'h100, 10'h100);
        step();
        check3("blk_px1", 10'h3FF, 10'h3FF, 10'h3FF);
        step();
        check3("blk_px2", 10'h100, 10'h100, 10'h100);

        // single white pixel, then blank clears disparity
        set_in(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        step();
        set_in(1'b0, 1'b1, 1'b0, 8'hFF);
        step();
        set_in(1'b1, 1'b0, 1'b1, 8'h00);
        step();
        step();
        check3("white_px", 10'h200, 10'h200, 10'h200);
        step();
        check3("white_tok", 10'h154, 10'h354, 10'h354);
        set_in(1'b0, 1'b1, 1'b1, 8'h00);
        repeat (3) step();
        check3("post_blank_px", 10'h100, 10'h100, 10'h100);

        // mixed colour 0xA9 twice: r8=B6, g8=49, b8=55
        set_in(1'b1, 1'b1, 1'b1, 8'h00);
        step();
        set_in(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        set_in(1'b0, 1'b1, 1'b0, 8'hA9);
        repeat (3) step();
        check3("mix_px0", 10'h133, 10'h1C7, 10'h2C7);
        step();
        check3("mix_px1", 10'h133, 10'h338, 10'h038);

        // short synthetic frame; line 1 is all white
        m_par     = 1'b0;
        m_hs_prev = 1'b1;
        m_vs_prev = 1'b0;
        for (int c = 0; c < 3; c++) disp[c] = 0;
        exp_q.delete();
        for (int ln = 0; ln < 6; ln++) begin
            for (int i = 0; i < 12; i++)
                drive_px(1'b1, !(i >= 4 && i < 8), !(ln == 0 && i >= 8), 8'h00);
            for (int i = 0; i < 40; i++)
                drive_px(1'b0, 1'b1, 1'b1, (ln == 1) ? 8'hFF : 8'($urandom_range(0, 255)));
        end
        repeat (4) drive_px(1'b1, 1'b1, 1'b1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
